// File: rtl/nand_seq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nand_seq_pkg : op codes, FSM/source/destination encodings, step counts.
// Revision 1.0
// ---------------------------------------------------------------------------
package nand_seq_pkg;

    localparam logic [2:0] OP_NOT  = 3'd0;
    localparam logic [2:0] OP_NAND = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
    typedef enum logic [2:0] {SRC_X, SRC_Y, SRC_T1, SRC_T2, SRC_T3} src_e;
    typedef enum logic [1:0] {DST_T1, DST_T2, DST_T3, DST_R} dst_e;

    function automatic logic [2:0] steps_of(input logic [2:0] op);
        case (op)
            OP_AND:          steps_of = 3'd2;
            OP_OR:           steps_of = 3'd3;
            OP_NOR, OP_XOR:  steps_of = 3'd4;
            OP_XNOR:         steps_of = 3'd5;
            default:         steps_of = 3'd1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/nand_seq_ucode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nand_seq_ucode : (op, step) -> NAND operand sources, destination, last flag.
// Revision 1.0
// ---------------------------------------------------------------------------
module nand_seq_ucode
    import nand_seq_pkg::*;
(
    input  logic [2:0] op_i,
    input  logic [2:0] step_i,
    output src_e       src_a_o,
    output src_e       src_b_o,
    output dst_e       dst_o,
    output logic       last_o
);

    always_comb begin
        src_a_o = SRC_X;
        src_b_o = SRC_X;
        dst_o   = DST_R;
        case (op_i)
            OP_NAND: src_b_o = SRC_Y;
            OP_AND: begin
                if (step_i == 3'd0) begin
                    src_b_o = SRC_Y; dst_o = DST_T1;
                end else begin
                    src_a_o = SRC_T1; src_b_o = SRC_T1;
                end
            end
            OP_OR, OP_NOR: begin
                case (step_i)
                    3'd0: dst_o = DST_T1;
                    3'd1: begin src_a_o = SRC_Y;  src_b_o = SRC_Y;  dst_o = DST_T2; end
                    3'd2: begin
                        src_a_o = SRC_T1; src_b_o = SRC_T2;
                        dst_o   = (op_i == OP_NOR) ? DST_T3 : DST_R;
                    end
                    default: begin src_a_o = SRC_T3; src_b_o = SRC_T3; end
                endcase
            end
            OP_XOR, OP_XNOR: begin
                // XNOR re-uses T1 once XOR's first three steps no longer need it
                case (step_i)
                    3'd0: begin src_b_o = SRC_Y; dst_o = DST_T1; end
                    3'd1: begin src_b_o = SRC_T1; dst_o = DST_T2; end
                    3'd2: begin src_a_o = SRC_Y; src_b_o = SRC_T1; dst_o = DST_T3; end
                    3'd3: begin
                        src_a_o = SRC_T2; src_b_o = SRC_T3;
                        dst_o   = (op_i == OP_XNOR) ? DST_T1 : DST_R;
                    end
                    default: begin src_a_o = SRC_T1; src_b_o = SRC_T1; end
                endcase
            end
            default: ;
        endcase
    end

    assign last_o = (step_i == (steps_of(op_i) - 3'd1));

endmodule
`default_nettype wire

// File: rtl/nand_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nand_seq_ctrl : bit-serial logic unit built on one shared external NAND cell.
// Revision 1.0
// ---------------------------------------------------------------------------
module nand_seq_ctrl
    import nand_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [2:0]   in_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_y,
    output logic         out_err,
    output logic         nand_a,
    output logic         nand_b,
    input  logic         nand_y,
    output logic         busy
);

    localparam int              IDXW     = (W > 1) ? $clog2(W) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(W - 1);

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, acc_q, acc_d, y_q, y_d;
    logic [2:0]      op_q, op_d, step_q, step_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            t1_q, t1_d, t2_q, t2_d, t3_q, t3_d, err_q, err_d;

    src_e  w_src_a, w_src_b;
    dst_e  w_dst;
    logic  w_last, w_x, w_y, w_sel_a, w_sel_b;

    nand_seq_ucode u_ucode (
        .op_i    (op_q),
        .step_i  (step_q),
        .src_a_o (w_src_a),
        .src_b_o (w_src_b),
        .dst_o   (w_dst),
        .last_o  (w_last)
    );

    assign w_x = a_q[idx_q];
    assign w_y = b_q[idx_q];

    always_comb begin
        case (w_src_a)
            SRC_X:   w_sel_a = w_x;
            SRC_Y:   w_sel_a = w_y;
            SRC_T1:  w_sel_a = t1_q;
            SRC_T2:  w_sel_a = t2_q;
            default: w_sel_a = t3_q;
        endcase
        case (w_src_b)
            SRC_X:   w_sel_b = w_x;
            SRC_Y:   w_sel_b = w_y;
            SRC_T1:  w_sel_b = t1_q;
            SRC_T2:  w_sel_b = t2_q;
            default: w_sel_b = t3_q;
        endcase
    end

    assign nand_a    = (state_q == ST_RUN) & w_sel_a;
    assign nand_b    = (state_q == ST_RUN) & w_sel_b;
    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_y     = y_q;
    assign out_err   = err_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        idx_d   = idx_q;
        step_d  = step_q;
        t1_d    = t1_q;
        t2_d    = t2_q;
        t3_d    = t3_q;
        acc_d   = acc_q;
        y_d     = y_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d    = in_a;
                    b_d    = in_b;
                    op_d   = in_op;
                    idx_d  = '0;
                    step_d = 3'd0;
                    if (in_op == OP_ILL) begin
                        state_d = ST_DONE;
                        y_d     = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                case (w_dst)
                    DST_T1:  t1_d = nand_y;
                    DST_T2:  t2_d = nand_y;
                    DST_T3:  t3_d = nand_y;
                    default: acc_d[idx_q] = nand_y;
                endcase
                if (w_last) begin
                    step_d = 3'd0;
                    if (idx_q == LAST_IDX) begin
                        // Result becomes visible only here, so partial bits never leak out.
                        idx_d   = '0;
                        state_d = ST_DONE;
                        y_d     = acc_d;
                        err_d   = 1'b0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 3'd0;
            idx_q   <= '0;
            step_q  <= 3'd0;
            t1_q    <= 1'b0;
            t2_q    <= 1'b0;
            t3_q    <= 1'b0;
            acc_q   <= '0;
            y_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            step_q  <= step_d;
            t1_q    <= t1_d;
            t2_q    <= t2_d;
            t3_q    <= t3_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            err_q   <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nand_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_nand_seq_ctrl : directed bench for nand_seq_ctrl with a behavioural NAND cell.
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_nand_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic [7:0] in_a, in_b;
    logic [2:0] in_op;
    logic       out_valid, out_ready;
    logic [7:0] out_y;
    logic       out_err, nand_a, nand_b, nand_y, busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign nand_y = ~(nand_a & nand_b);

    nand_seq_ctrl #(.W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_err   (out_err),
        .nand_a    (nand_a),
        .nand_b    (nand_b),
        .nand_y    (nand_y),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts cycles from the one after the accept edge until out_valid is seen.
    task automatic wait_valid(input string tag, input int exp_cyc);
        int cyc;
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_latency"}, cyc, exp_cyc);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp_y, input int exp_cyc);
        chk({tag, "_in_ready"}, in_ready, 1);
        in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(tag, exp_cyc);
        chk({tag, "_y"}, out_y, exp_y);
        chk({tag, "_err"}, out_err, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] va, vb;
        #200000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic [7:0] va, vb;
        rst_n = 1'b0; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_op = 3'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_y", out_y, 8'h00);
        chk("rst_out_err", out_err, 0);
        chk("rst_nand", {nand_a, nand_b}, 2'b00);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // NAND with per-bit view of the cell inputs
        va = 8'hF0; vb = 8'hCC;
        in_op = 3'd1; in_a = va; in_b = vb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("nand_bit%0d_ab", i), {nand_a, nand_b}, {va[i], vb[i]});
            chk($sformatf("nand_bit%0d_valid", i), out_valid, 0);
            @(posedge clk); #1;
        end
        chk("nand_valid_at9", out_valid, 1);
        chk("nand_y", out_y, 8'h3F);
        chk("nand_err", out_err, 0);
        @(posedge clk); #1;

        run_op("xor",  3'd5, 8'hF0, 8'hCC, 8'h3C, 33);
        run_op("xnor", 3'd6, 8'hF0, 8'hCC, 8'hC3, 41);
        run_op("or",   3'd3, 8'hF0, 8'hCC, 8'hFC, 25);
        run_op("nor",  3'd4, 8'hF0, 8'hCC, 8'h03, 33);
        run_op("and",  3'd2, 8'hF0, 8'hCC, 8'hC0, 17);
        run_op("not",  3'd0, 8'h5A, 8'hFF, 8'hA5, 9);

        // Illegal op
        in_op = 3'd7; in_a = 8'hAA; in_b = 8'h55; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("ill_valid", out_valid, 1);
        chk("ill_err", out_err, 1);
        chk("ill_y", out_y, 8'h00);
        chk("ill_nand", {nand_a, nand_b}, 2'b00);
        @(posedge clk); #1;
        chk("ill_done_idle", in_ready, 1);

        // Backpressure in DONE, with a request held valid throughout
        out_ready = 1'b0;
        in_op = 3'd2; in_a = 8'hF0; in_b = 8'hCC; in_valid = 1'b1;
        @(posedge clk); #1;
        wait_valid("bp", 17);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold%0d_valid", i), out_valid, 1);
            chk($sformatf("bp_hold%0d_y", i), out_y, 8'hC0);
            chk($sformatf("bp_hold%0d_in_ready", i), in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        chk("bp_last_valid", out_valid, 1);
        @(posedge clk); #1;
        chk("bp_after_hs_valid", out_valid, 0);
        chk("bp_after_hs_busy", busy, 0);
        chk("bp_after_hs_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_second_accept", busy, 1);
        wait_valid("bp2", 17);
        chk("bp2_y", out_y, 8'hC0);
        @(posedge clk); #1;

        // Reset during XOR on bit 3
        in_op = 3'd5; in_a = 8'hF0; in_b = 8'hCC; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("xrst_bit3_ab", {nand_a, nand_b}, 2'b01);
        chk("xrst_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("xrst_busy", busy, 0);
        chk("xrst_in_ready", in_ready, 1);
        chk("xrst_valid", out_valid, 0);
        chk("xrst_y", out_y, 8'h00);
        chk("xrst_nand", {nand_a, nand_b}, 2'b00);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("post_rst_nand", 3'd1, 8'hFF, 8'h01, 8'hFE, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
